// File: rtl/fact_pkg.sv
// Shared types and constants for the iterative factorial unit (fact_ctrl / fact_dp).
package fact_pkg;

  localparam int DEFAULT_MAX_N = 12;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MUL,
    DONE,
    ERR
  } state_t;

  // Selects what the single shared A > B comparator looks at.
  typedef enum logic {
    CMP_RANGE,
    CMP_LOOP
  } cmp_sel_t;

endpackage

// File: rtl/fact_dp.sv
// Factorial datapath: down-counter, product register, multiplier and the shared comparator.
// The range-check operands are only selected by the FSM when FACT_OVF_CHECK_EN is defined.
module fact_dp
  import fact_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_W   = 4,
  parameter int MAX_N = DEFAULT_MAX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic             mul,
  input  cmp_sel_t         cmp_sel,
  input  logic [N_W-1:0]   n,
  output logic             gt,
  output logic [WIDTH-1:0] prod
);

  localparam logic [31:0] MAX_B = MAX_N;

  logic [N_W-1:0]   cnt;
  logic [WIDTH-1:0] cnt_ext;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;

  assign cnt_ext = {{(WIDTH-N_W){1'b0}}, cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      prod <= '0;
    end else if (load) begin
      cnt  <= n;
      prod <= {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      if (mul) prod <= prod * cnt_ext;
      if (dec) cnt  <= cnt - N_W'(1);
    end
  end

  // Time-shared comparator: range check while idle, loop test otherwise.
  always_comb begin
    cmp_a = 32'(cnt);
    cmp_b = 32'd1;
    if (cmp_sel == CMP_RANGE) begin
      cmp_a = 32'(n);
      cmp_b = MAX_B;
    end
  end

  assign gt = cmp_a > cmp_b;

endmodule

// File: rtl/fact_ctrl.sv
// Iterative factorial unit: control FSM sequencing fact_dp with a go/done level handshake.
// Define FACT_OVF_CHECK_EN to reject n > MAX_N through the ERR state.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_W   = 4,
  parameter int MAX_N = DEFAULT_MAX_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [N_W-1:0]   n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  state_t     state;
  state_t     state_next;
  logic       load;
  logic       dec;
  logic       mul;
  logic       gt;
  cmp_sel_t   cmp_sel;
  logic [WIDTH-1:0] prod;

  fact_dp #(
    .WIDTH (WIDTH),
    .N_W   (N_W),
    .MAX_N (MAX_N)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .dec     (dec),
    .mul     (mul),
    .cmp_sel (cmp_sel),
    .n       (n),
    .gt      (gt),
    .prod    (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    dec        = 1'b0;
    mul        = 1'b0;
    cmp_sel    = CMP_LOOP;
    case (state)
      IDLE: begin
`ifdef FACT_OVF_CHECK_EN
        cmp_sel = CMP_RANGE;
        if (go) begin
          if (gt) begin
            state_next = ERR;
          end else begin
            state_next = CHECK;
            load       = 1'b1;
          end
        end
`else
        if (go) begin
          state_next = CHECK;
          load       = 1'b1;
        end
`endif
      end
      CHECK: state_next = gt ? MUL : DONE;
      MUL: begin
        mul        = 1'b1;
        dec        = 1'b1;
        state_next = CHECK;
      end
      // A held-high go parks here; only a low go rearms the unit.
      DONE: if (!go) state_next = IDLE;
`ifdef FACT_OVF_CHECK_EN
      ERR:  if (!go) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state == CHECK) || (state == MUL);
`ifdef FACT_OVF_CHECK_EN
  assign done   = (state == DONE) || (state == ERR);
  assign err    = (state == ERR);
`else
  assign done   = (state == DONE);
  assign err    = 1'b0;
`endif
  assign result = (state == DONE) ? prod : '0;

endmodule

// File: tb/tb_fact_ctrl.sv
// Self-checking bench for fact_ctrl: vector table, expected-result scoreboard, reset and handshake corners.
module tb_fact_ctrl;

  localparam int WIDTH = 32;
  localparam int N_W   = 4;
  localparam int MAX_N = 12;

  typedef struct {
    logic [N_W-1:0]   n;
    int               hold;
    logic [WIDTH-1:0] res;
    int               lat;
    logic             er;
    bit               change_n;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               lat;
    logic             er;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             go;
  logic [N_W-1:0]   n;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] result;

  exp_t sb[$];
  vec_t vecs[10];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fact_ctrl #(
    .WIDTH (WIDTH),
    .N_W   (N_W),
    .MAX_N (MAX_N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .n      (n),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pops the scoreboard entry for the run that just completed and compares it.
  task automatic check_output(input int lat, input bit busy_ok, input int hold);
    exp_t e;
    bit   stable;
    e = sb.pop_front();
    check("latency", 32'(lat), 32'(e.lat));
    check("result", result, e.res);
    check("err", 32'(err), 32'(e.er));
    check("busy_at_done", 32'(busy), 32'd0);
    check("busy_during_run", 32'(busy_ok), 32'd1);
    if (hold > 0) begin
      stable = 1'b1;
      for (int h = 0; h < hold; h++) begin
        step();
        if (!done || busy || result !== e.res) stable = 1'b0;
      end
      check("go_held_no_restart", 32'(stable), 32'd1);
    end
    go = 1'b0;
    step();
    check("done_drops", 32'(done), 32'd0);
    check("err_drops", 32'(err), 32'd0);
  endtask

  task automatic apply_stimulus(input vec_t v);
    int cyc;
    bit got;
    bit busy_ok;
    n       = v.n;
    go      = 1'b1;
    sb.push_back('{res: v.res, lat: v.lat, er: v.er});
    cyc     = 0;
    got     = 1'b0;
    busy_ok = 1'b1;
    while (!got && cyc < 200) begin
      step();
      cyc++;
      if (v.change_n && cyc == 3) n = 4'd9;
      if (done) got = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL timeout: n=%0d no done after %0d cycles, expected %0d", v.n, cyc, v.lat);
      void'(sb.pop_front());
      go = 1'b0;
      step();
    end else begin
      check_output(cyc, busy_ok, v.hold);
    end
  endtask

  initial begin
    vecs[0] = '{n: 4'd0,  hold: 0,  res: 32'd1,         lat: 2,  er: 1'b0, change_n: 1'b0};
    vecs[1] = '{n: 4'd1,  hold: 0,  res: 32'd1,         lat: 2,  er: 1'b0, change_n: 1'b0};
    vecs[2] = '{n: 4'd5,  hold: 0,  res: 32'd120,       lat: 10, er: 1'b0, change_n: 1'b1};
    vecs[3] = '{n: 4'd12, hold: 10, res: 32'd479001600, lat: 24, er: 1'b0, change_n: 1'b0};
    vecs[4] = '{n: 4'd4,  hold: 0,  res: 32'd24,        lat: 8,  er: 1'b0, change_n: 1'b0};
    vecs[5] = '{n: 4'd2,  hold: 0,  res: 32'd2,         lat: 4,  er: 1'b0, change_n: 1'b0};
    vecs[6] = '{n: 4'd7,  hold: 3,  res: 32'd5040,      lat: 14, er: 1'b0, change_n: 1'b0};
`ifdef FACT_OVF_CHECK_EN
    vecs[7] = '{n: 4'd13, hold: 2,  res: 32'd0,         lat: 1,  er: 1'b1, change_n: 1'b0};
    vecs[8] = '{n: 4'd15, hold: 0,  res: 32'd0,         lat: 1,  er: 1'b1, change_n: 1'b0};
`else
    vecs[7] = '{n: 4'd13, hold: 2,  res: 32'd1932053504, lat: 26, er: 1'b0, change_n: 1'b0};
    vecs[8] = '{n: 4'd15, hold: 0,  res: 32'd2004310016, lat: 30, er: 1'b0, change_n: 1'b0};
`endif
    vecs[9] = '{n: 4'd3,  hold: 0,  res: 32'd6,         lat: 6,  er: 1'b0, change_n: 1'b0};

    rst = 1'b1;
    go  = 1'b0;
    n   = '0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;
    step();

    // Each run re-raises go in the IDLE cycle right after the previous done drops.
    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i]);

    // Reset mid-run with go still high: reset must win and abort the computation.
    n  = 4'd7;
    go = 1'b1;
    for (int c = 0; c < 5; c++) step();
    check("midrun_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_result", result, 32'd0);
    rst = 1'b0;
    go  = 1'b0;
    step();
    check("idle_after_rst", 32'(busy | done), 32'd0);
    apply_stimulus('{n: 4'd3, hold: 0, res: 32'd6, lat: 6, er: 1'b0, change_n: 1'b0});

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
